lifo_arbiter: RTL and testbench

//  Shares one lifo instance between N_REQ requesters. Each requester issues push/pop

---
 rtl/lifo_arb_pkg.sv | 28 ++
 rtl/lifo_arbiter_rr_arbiter.sv | 41 ++++
 rtl/lifo_arbiter.sv | 143 ++++++++++++++
 tb/tb_lifo_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lifo_arb_pkg.sv
// Shared types and constants for the LIFO front-end arbiter.
package lifo_arb_pkg;

    // Request sequencing: one request in flight from accept to response
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Response status codes as seen on resp_status
    typedef enum logic [1:0] {
        OK    = 2'b00,
        FULL  = 2'b01,
        EMPTY = 2'b10
    } status_t;

    // Per-requester operation encoding on req_op
    localparam logic OP_PUSH = 1'b1;
    localparam logic OP_POP  = 1'b0;

    // Round-robin successor of a requester index, wrapping at n
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return ((idx + 1) >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/lifo_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N. The pointer register is owned by the instantiating block.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any_req
);

    logic [IW:0]   cand_sum [N];
    logic [IW-1:0] cand_idx [N];

    // Candidate index for each search offset, already wrapped into 0..N-1
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cand
            assign cand_sum[gi] = {1'b0, ptr} + (IW+1)'(gi);
            assign cand_idx[gi] = (cand_sum[gi] >= (IW+1)'(N))
                                  ? IW'(cand_sum[gi] - (IW+1)'(N))
                                  : cand_sum[gi][IW-1:0];
        end
    endgenerate

    // Scan offsets in priority order; the first hit wins
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any_req && req[cand_idx[k]]) begin
                any_req               = 1'b1;
                grant_idx             = cand_idx[k];
                grant[cand_idx[k]]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lifo_arbiter.sv
// Shares one LIFO between N_REQ requesters: round-robin accept, one operation
// in flight, full/empty checked before any strobe, one-hot response per request.
module lifo_arbiter
    import lifo_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ-1:0]            req_op,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    output logic [N_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]       resp_data,
    output logic [1:0]                  resp_status,
    output logic                        lifo_wr_en,
    output logic [DATA_WIDTH-1:0]       lifo_data_wr,
    output logic                        lifo_rd_en,
    input  logic [DATA_WIDTH-1:0]       lifo_data_rd,
    input  logic                        lifo_full,
    input  logic                        lifo_empty
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t                  state_reg;
    state_t                  state_next;
    logic [IW-1:0]           rr_ptr_reg;
    logic [IW-1:0]           id_reg;
    logic                    op_reg;
    logic [DATA_WIDTH-1:0]   data_reg;
    logic [DATA_WIDTH-1:0]   resp_data_reg;
    status_t                 status_reg;

    logic [N_REQ-1:0]        grant;
    logic [IW-1:0]           grant_idx;
    logic                    any_req;
    logic                    accept;
    logic [DATA_WIDTH-1:0]   req_slice [N_REQ];

    // Unpack the flat push-data bus into one word per requester
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign req_slice[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr_reg),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    // A request is taken only while idle
    assign accept = (state_reg == IDLE) && any_req;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state: pops that can proceed take an extra cycle to collect read data
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:   if (any_req) state_next = ISSUE;
            ISSUE:  begin
                if (op_reg == OP_POP && !lifo_empty) state_next = RDWAIT;
                else                                 state_next = RESP;
            end
            RDWAIT: state_next = RESP;
            RESP:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs: strobes only in ISSUE and only when the flag permits
    always_comb begin
        req_ready  = accept ? grant : '0;
        lifo_wr_en = (state_reg == ISSUE) && (op_reg == OP_PUSH) && !lifo_full;
        lifo_rd_en = (state_reg == ISSUE) && (op_reg == OP_POP)  && !lifo_empty;
        resp_valid = '0;
        if (state_reg == RESP) begin
            resp_valid[id_reg] = 1'b1;
        end
    end

    assign lifo_data_wr = data_reg;
    assign resp_data    = resp_data_reg;
    assign resp_status  = status_reg;

    // Latch the accepted request and advance the round-robin pointer past it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg <= '0;
            id_reg     <= '0;
            op_reg     <= 1'b0;
            data_reg   <= '0;
        end else if (accept) begin
            rr_ptr_reg <= IW'(rr_next(int'(grant_idx), N_REQ));
            id_reg     <= grant_idx;
            op_reg     <= req_op[grant_idx];
            data_reg   <= req_slice[grant_idx];
        end
    end

    // Build the response word; it then holds until the next operation updates it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_data_reg <= '0;
            status_reg    <= OK;
        end else begin
            case (state_reg)
                ISSUE: begin
                    if (op_reg == OP_PUSH) begin
                        resp_data_reg <= '0;
                        status_reg    <= lifo_full ? FULL : OK;
                    end else if (lifo_empty) begin
                        resp_data_reg <= '0;
                        status_reg    <= EMPTY;
                    end
                end
                RDWAIT: begin
                    resp_data_reg <= lifo_data_rd;
                    status_reg    <= OK;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lifo_arbiter.sv
// Directed bench for lifo_arbiter in front of a 4-deep behavioural LIFO.
module tb_lifo_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_op;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [3:0]  resp_valid;
    logic [7:0]  resp_data;
    logic [1:0]  resp_status;
    logic        lifo_wr_en;
    logic [7:0]  lifo_data_wr;
    logic        lifo_rd_en;
    logic [7:0]  lifo_data_rd;
    logic        lifo_full;
    logic        lifo_empty;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;

    lifo_arbiter #(.N_REQ(4), .DATA_WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_op       (req_op),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .resp_status  (resp_status),
        .lifo_wr_en   (lifo_wr_en),
        .lifo_data_wr (lifo_data_wr),
        .lifo_rd_en   (lifo_rd_en),
        .lifo_data_rd (lifo_data_rd),
        .lifo_full    (lifo_full),
        .lifo_empty   (lifo_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural LIFO, DEPTH=4, registered read data
    logic [7:0] lifo_mem [4];
    int lifo_cnt = 0;
    initial lifo_data_rd = 8'h00;
    always @(posedge clk) begin
        if (lifo_wr_en && lifo_cnt < 4) begin
            lifo_mem[lifo_cnt] <= lifo_data_wr;
            lifo_cnt <= lifo_cnt + 1;
        end else if (lifo_rd_en && lifo_cnt > 0) begin
            lifo_data_rd <= lifo_mem[lifo_cnt-1];
            lifo_cnt <= lifo_cnt - 1;
        end
    end
    assign lifo_full  = (lifo_cnt == 4);
    assign lifo_empty = (lifo_cnt == 0);

    always @(posedge clk) begin
        if (lifo_wr_en) wr_cnt++;
        if (lifo_rd_en) rd_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Per-cycle invariants: exclusive strobes, one-hot ready and response
    always @(negedge clk) begin
        if (rst_n) begin
            check_eq("strobe_excl", 32'(lifo_wr_en & lifo_rd_en), 32'd0);
            check_eq("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
            check_eq("resp_onehot", 32'($onehot0(resp_valid)), 32'd1);
        end
    end

    task automatic wait_ready(input string tag, input int id, output int acc);
        logic seen;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (req_ready[id]) seen = 1'b1;
        end
        check_eq({tag, "_accept"}, 32'(seen), 32'd1);
        acc = cyc;
    endtask

    task automatic wait_resp(input string tag, input int id, input int acc,
                             input logic [1:0] st, input logic [7:0] d, input int lat);
        logic       seen;
        logic [3:0] exp_v;
        seen  = 1'b0;
        exp_v = 4'b0001 << id;
        for (int t = 0; t < 12 && !seen; t++) begin
            @(negedge clk);
            if (|resp_valid) seen = 1'b1;
        end
        check_eq({tag, "_resp_valid"}, 32'(resp_valid), 32'(exp_v));
        check_eq({tag, "_status"}, 32'(resp_status), 32'(st));
        check_eq({tag, "_data"}, 32'(resp_data), 32'(d));
        check_eq({tag, "_latency"}, 32'(cyc - acc), 32'(lat));
        $display("txn %s: req%0d status=%0d data=0x%02h latency=%0d",
                 tag, id, resp_status, resp_data, cyc - acc);
    endtask

    task automatic single(input string tag, input int id, input logic op, input logic [7:0] din,
                          input logic [1:0] st, input logic [7:0] d, input int lat);
        int acc;
        @(posedge clk); #1;
        req_valid[id] = 1'b1;
        req_op[id] = op;
        req_data[id*8 +: 8] = din;
        wait_ready(tag, id, acc);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        wait_resp(tag, id, acc, st, d, lat);
    endtask

    // Several requesters push at once; grants must follow the given order
    task automatic push_group(input string tag, input logic [3:0] mask, input logic [7:0] base,
                              input int o0, input int o1, input int o2, input int o3, input int n);
        int order[4];
        int g;
        int acc;
        order = '{o0, o1, o2, o3};
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                req_valid[i] = 1'b1;
                req_op[i] = 1'b1;
                req_data[i*8 +: 8] = base + 8'(i);
            end
        end
        for (int k = 0; k < n; k++) begin
            g = -1;
            for (int t = 0; t < 20 && g < 0; t++) begin
                @(negedge clk);
                for (int i = 0; i < 4; i++) if (req_ready[i]) g = i;
            end
            acc = cyc;
            check_eq({tag, "_grant"}, 32'(g), 32'(order[k]));
            @(posedge clk); #1;
            if (g >= 0) req_valid[g] = 1'b0;
            wait_resp(tag, order[k], acc, 2'b00, 8'h00, 2);
        end
        req_valid = '0;
    endtask

    initial begin
        int acc;
        int wr0;
        int rd0;
        rst_n = 1'b0;
        req_valid = '0;
        req_op = '0;
        req_data = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_strobes", 32'({lifo_wr_en, lifo_rd_en}), 32'd0);
        check_eq("rst_resp_data", 32'(resp_data), 32'd0);
        check_eq("rst_status", 32'(resp_status), 32'd0);
        check_eq("rst_data_wr", 32'(lifo_data_wr), 32'd0);
        rst_n = 1'b1;

        // 1: push then pop by req0
        single("t1_push", 0, 1'b1, 8'hA5, 2'b00, 8'h00, 2);
        single("t1_pop", 0, 1'b0, 8'h00, 2'b00, 8'hA5, 3);

        // 4: pop on empty by req3 (also returns the pointer to 0)
        rd0 = rd_cnt;
        single("t4_empty", 3, 1'b0, 8'h00, 2'b10, 8'h00, 2);
        check_eq("t4_no_rd_en", 32'(rd_cnt - rd0), 32'd0);

        // 2: all four push together, grants in index order
        push_group("t2", 4'b1111, 8'h10, 0, 1, 2, 3, 4);

        // 3: push into a full LIFO is rejected without a write strobe
        wr0 = wr_cnt;
        single("t3_full", 1, 1'b1, 8'h77, 2'b01, 8'h00, 2);
        check_eq("t3_no_wr_en", 32'(wr_cnt - wr0), 32'd0);

        // 2 (cont.) / 3: drain by req2, newest first
        single("t2_pop0", 2, 1'b0, 8'h00, 2'b00, 8'h13, 3);
        single("t2_pop1", 2, 1'b0, 8'h00, 2'b00, 8'h12, 3);
        single("t2_pop2", 2, 1'b0, 8'h00, 2'b00, 8'h11, 3);
        single("t2_pop3", 2, 1'b0, 8'h00, 2'b00, 8'h10, 3);

        // 5: grant req3, then req0 and req2 contend -> req0 first after wrap
        single("t5_req3", 3, 1'b1, 8'h31, 2'b00, 8'h00, 2);
        push_group("t5", 4'b0101, 8'h40, 0, 2, 0, 0, 2);

        // 6: reset while waiting for pop data
        @(posedge clk); #1;
        req_valid[0] = 1'b1;
        req_op[0] = 1'b0;
        wait_ready("t6", 0, acc);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check_eq("t6_rd_en_issue", 32'(lifo_rd_en), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("t6_rst_strobes", 32'({lifo_wr_en, lifo_rd_en}), 32'd0);
        check_eq("t6_rst_data_wr", 32'(lifo_data_wr), 32'd0);
        check_eq("t6_rst_resp_data", 32'(resp_data), 32'd0);
        check_eq("t6_rst_status", 32'(resp_status), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t6_no_resp", 32'(resp_valid), 32'd0);
        end
        rst_n = 1'b1;
        $display("txn t6: reset during pop, no response delivered");

        // 6 (cont.): the interrupted pop already removed 0x42
        single("t6_push", 1, 1'b1, 8'h55, 2'b00, 8'h00, 2);
        single("t6_pop0", 1, 1'b0, 8'h00, 2'b00, 8'h55, 3);
        single("t6_pop1", 0, 1'b0, 8'h00, 2'b00, 8'h40, 3);
        single("t6_pop2", 3, 1'b0, 8'h00, 2'b00, 8'h31, 3);
        single("t6_pop3", 2, 1'b0, 8'h00, 2'b10, 8'h00, 2);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
